// File: rtl/etpu_pkg.sv
// Shared constants, register offsets and sequencer state encoding for the
// sysa_seq Wishbone sequencer.
package etpu_pkg;

    localparam logic [31:0] BASE_ADDRESS = 32'h3000_0000;
    localparam int          DW           = 8;
    localparam int          ARRAY_N      = 3;
    localparam int          N_OPS        = 7;
    localparam int          N_RES        = ARRAY_N * ARRAY_N;
    localparam int          ROW_W        = ARRAY_N * DW;
    localparam int          RES_W        = 16;

    localparam logic [6:0]  WIN_BYTES    = 7'h44;
    localparam logic [6:0]  OFS_CTRL     = 7'h00;
    localparam logic [6:0]  OFS_STATUS   = 7'h04;
    localparam logic [6:0]  OFS_WGT0     = 7'h08;
    localparam logic [6:0]  OFS_IN0      = 7'h14;
    localparam logic [6:0]  OFS_RES0     = 7'h20;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_FINISH = 3'd3
    } state_t;

endpackage

// File: rtl/sysa_seq_regs.sv
// Wishbone decode, single-cycle ack generation and register file for sysa_seq.
// CTRL pulses are decoded combinationally so they act on the ack edge.
module sysa_seq_regs
    import etpu_pkg::*;
(
    input  logic               clock,
    input  logic               rst_n,
    input  logic               wb_stb_i,
    input  logic               wb_cyc_i,
    input  logic               wb_we_i,
    input  logic [3:0]         wb_sel_i,
    input  logic [31:0]        wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    output logic               wb_ack_o,
    output logic [31:0]        wb_dat_o,
    input  logic               busy,
    input  logic               done,
    input  state_t             state,
    input  logic [N_RES-1:0]   cap_we,
    input  logic [RES_W-1:0]   cap_dat [N_RES],
    output logic               start_p,
    output logic               soft_clr_p,
    output logic               irq_en,
    output logic [ROW_W-1:0]   wgt     [ARRAY_N],
    output logic [ROW_W-1:0]   in_rows [ARRAY_N]
);

    logic [4:0]       widx;
    logic             in_win;
    logic             acc;
    logic             wr;
    logic             ctrl_wr;
    logic [31:0]      rd_val;
    logic [RES_W-1:0] res [N_RES];
    logic             unused_ok;

    assign unused_ok  = ^{wb_sel_i, wb_dat_i[31:ROW_W]};
    assign widx       = wb_adr_i[6:2];
    assign in_win     = (wb_adr_i[31:7] == BASE_ADDRESS[31:7]) && (wb_adr_i[6:0] < WIN_BYTES);
    assign acc        = wb_stb_i & wb_cyc_i & in_win & ~wb_ack_o;
    assign wr         = acc & wb_we_i;
    assign ctrl_wr    = wr && (widx == OFS_CTRL[6:2]);
    // SOFT_CLR takes precedence over START within the same write.
    assign soft_clr_p = ctrl_wr && wb_dat_i[1];
    assign start_p    = ctrl_wr && wb_dat_i[0] && !wb_dat_i[1];

    always_comb begin
        rd_val = '0;
        if (widx == OFS_CTRL[6:2])
            rd_val[2] = irq_en;
        if (widx == OFS_STATUS[6:2])
            rd_val[4:0] = {state, done, busy};
        for (int unsigned i = 0; i < ARRAY_N; i++) begin
            if (widx == OFS_WGT0[6:2] + 5'(i))
                rd_val[ROW_W-1:0] = wgt[i];
            if (widx == OFS_IN0[6:2] + 5'(i))
                rd_val[ROW_W-1:0] = in_rows[i];
        end
        for (int unsigned i = 0; i < N_RES; i++) begin
            if (widx == OFS_RES0[6:2] + 5'(i))
                rd_val[RES_W-1:0] = res[i];
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            irq_en   <= 1'b0;
            for (int unsigned i = 0; i < ARRAY_N; i++) begin
                wgt[i]     <= '0;
                in_rows[i] <= '0;
            end
        end else begin
            wb_ack_o <= acc;
            if (acc && !wb_we_i)
                wb_dat_o <= rd_val;
            if (ctrl_wr)
                irq_en <= wb_dat_i[2];
            for (int unsigned i = 0; i < ARRAY_N; i++) begin
                if (wr && !busy && widx == OFS_WGT0[6:2] + 5'(i))
                    wgt[i] <= wb_dat_i[ROW_W-1:0];
                if (wr && !busy && widx == OFS_IN0[6:2] + 5'(i))
                    in_rows[i] <= wb_dat_i[ROW_W-1:0];
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_RES; i++)
                res[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < N_RES; i++) begin
                if (soft_clr_p)
                    res[i] <= '0;
                else if (cap_we[i])
                    res[i] <= cap_dat[i];
            end
        end
    end

endmodule

// File: rtl/sysa_seq.sv
// Wishbone-mapped sequencer for the 3x3 sysa array: run FSM, ops counter and
// capture of the skewed column outputs into the result registers.
module sysa_seq
    import etpu_pkg::*;
(
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  wb_stb_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_we_i,
    input  logic [3:0]            wb_sel_i,
    input  logic [31:0]           wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    output logic                  wb_ack_o,
    output logic [31:0]           wb_dat_o,
    output logic                  sa_en,
    output logic                  sa_clr,
    output logic [N_RES*DW-1:0]   sa_w,
    output logic [ROW_W-1:0]      sa_in,
    input  logic [RES_W-1:0]      sa_out1,
    input  logic [RES_W-1:0]      sa_out2,
    input  logic [RES_W-1:0]      sa_out3,
    output logic                  irq
);

    state_t           state;
    logic [2:0]       ops;
    logic             busy;
    logic             done;
    logic             start_p;
    logic             soft_clr_p;
    logic             irq_en;
    logic [ROW_W-1:0] wgt     [ARRAY_N];
    logic [ROW_W-1:0] in_rows [ARRAY_N];
    logic [N_RES-1:0] cap_we;
    logic [RES_W-1:0] cap_dat [N_RES];

    sysa_seq_regs u_regs (
        .clock      (clock),
        .rst_n      (rst_n),
        .wb_stb_i   (wb_stb_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_we_i    (wb_we_i),
        .wb_sel_i   (wb_sel_i),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_o   (wb_ack_o),
        .wb_dat_o   (wb_dat_o),
        .busy       (busy),
        .done       (done),
        .state      (state),
        .cap_we     (cap_we),
        .cap_dat    (cap_dat),
        .start_p    (start_p),
        .soft_clr_p (soft_clr_p),
        .irq_en     (irq_en),
        .wgt        (wgt),
        .in_rows    (in_rows)
    );

    always_comb begin
        sa_w = '0;
        for (int unsigned r = 0; r < ARRAY_N; r++)
            sa_w[r*ROW_W +: ROW_W] = wgt[r];
    end

    always_comb begin
        sa_in = '0;
        for (int unsigned i = 0; i < ARRAY_N; i++) begin
            if (state == S_STREAM && ops == 3'(i))
                sa_in = in_rows[i];
        end
    end

    // Column c emits the result for row k at ops = k + 1 + c (array skew).
    always_comb begin
        cap_we  = '0;
        cap_dat = '{default: '0};
        for (int unsigned i = 0; i < ARRAY_N; i++) begin
            if (state == S_STREAM && ops == 3'(i + 1)) begin
                cap_we[i]  = 1'b1;
                cap_dat[i] = sa_out1;
            end
            if (state == S_STREAM && ops == 3'(i + 2)) begin
                cap_we[ARRAY_N + i]  = 1'b1;
                cap_dat[ARRAY_N + i] = sa_out2;
            end
            if (state == S_STREAM && ops == 3'(i + 3)) begin
                cap_we[2*ARRAY_N + i]  = 1'b1;
                cap_dat[2*ARRAY_N + i] = sa_out3;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            ops    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sa_en  <= 1'b0;
            sa_clr <= 1'b0;
            irq    <= 1'b0;
        end else begin
            irq <= done & irq_en;
            if (soft_clr_p) begin
                state  <= S_IDLE;
                ops    <= '0;
                busy   <= 1'b0;
                done   <= 1'b0;
                sa_en  <= 1'b0;
                sa_clr <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_p) begin
                            busy   <= 1'b1;
                            done   <= 1'b0;
                            sa_clr <= 1'b1;
                            state  <= S_CLEAR;
                        end
                    end
                    S_CLEAR: begin
                        sa_clr <= 1'b0;
                        sa_en  <= 1'b1;
                        ops    <= '0;
                        state  <= S_STREAM;
                    end
                    S_STREAM: begin
                        if (ops == 3'(N_OPS - 1)) begin
                            sa_en <= 1'b0;
                            state <= S_FINISH;
                        end else begin
                            ops <= ops + 3'd1;
                        end
                    end
                    S_FINISH: begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sysa_seq.sv
// Self-checking bench for sysa_seq: behavioural sysa array, timeline/register
// model of the sequencer checked every cycle, plus directed literal checks.
module tb_sysa_seq;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] adr = '0, dat = '0;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;
    logic        sa_en, sa_clr, irq;
    logic [71:0] sa_w;
    logic [23:0] sa_in;
    logic [15:0] sa_out1, sa_out2, sa_out3;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    sysa_seq dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .wb_stb_i (stb),
        .wb_cyc_i (cyc),
        .wb_we_i  (we),
        .wb_sel_i (sel),
        .wb_adr_i (adr),
        .wb_dat_i (dat),
        .wb_ack_o (wb_ack_o),
        .wb_dat_o (wb_dat_o),
        .sa_en    (sa_en),
        .sa_clr   (sa_clr),
        .sa_w     (sa_w),
        .sa_in    (sa_in),
        .sa_out1  (sa_out1),
        .sa_out2  (sa_out2),
        .sa_out3  (sa_out3),
        .irq      (irq)
    );

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural array: each enabled cycle records the row fed in; column c
    // presents the dot product of the row fed 1+c cycles earlier.
    logic [23:0] hist [16] = '{default: '0};
    int t = 0;

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            t <= 0;
        end else if (sa_clr) begin
            t <= 0;
            for (int i = 0; i < 16; i++) hist[i] <= '0;
        end else if (sa_en && t < 16) begin
            hist[t] <= sa_in;
            t <= t + 1;
        end
    end

    function automatic logic [15:0] col_dot(input logic [23:0] row, input logic [71:0] w, input int c);
        int s = 0;
        for (int r = 0; r < 3; r++)
            s += int'(row[r*8 +: 8]) * int'(w[(r*3 + c)*8 +: 8]);
        return 16'(s);
    endfunction

    always_comb begin
        sa_out1 = (t >= 1) ? col_dot(hist[t-1], sa_w, 0) : 16'h0;
        sa_out2 = (t >= 2) ? col_dot(hist[t-2], sa_w, 1) : 16'h0;
        sa_out3 = (t >= 3) ? col_dot(hist[t-3], sa_w, 2) : 16'h0;
    end

    // Sequencer model: phase counts cycles since the START ack edge
    // (0 clear, 1..7 stream, 8 finish, -1 idle).
    logic        m_ack = 1'b0;
    logic [31:0] m_dat = '0;
    logic        m_irq_en = 1'b0, m_done = 1'b0, m_irq = 1'b0;
    logic [23:0] m_wgt [3] = '{default: '0};
    logic [23:0] m_in  [3] = '{default: '0};
    logic [15:0] m_res [9] = '{default: '0};
    int          m_phase = -1;
    logic        b_acc;
    int          b_idx;

    function automatic logic in_window(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'h44);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int idx = int'((a - BASE) >> 2);
        logic [2:0] st;
        st = (m_phase < 0) ? 3'd0 : (m_phase == 0) ? 3'd1 : (m_phase <= 7) ? 3'd2 : 3'd3;
        if (idx == 0) return {29'b0, m_irq_en, 2'b0};
        if (idx == 1) return {27'b0, st, m_done, m_phase >= 0};
        if (idx >= 2 && idx <= 4) return {8'b0, m_wgt[idx-2]};
        if (idx >= 5 && idx <= 7) return {8'b0, m_in[idx-5]};
        if (idx >= 8 && idx <= 16) return {16'b0, m_res[idx-8]};
        return 32'h0;
    endfunction

    function automatic logic [15:0] prod(input int k, input int c);
        int s = 0;
        for (int r = 0; r < 3; r++)
            s += int'(m_in[k][r*8 +: 8]) * int'(m_wgt[r][c*8 +: 8]);
        return 16'(s);
    endfunction

    function automatic logic [23:0] exp_in();
        if (m_phase >= 1 && m_phase <= 3) return m_in[m_phase-1];
        return 24'h0;
    endfunction

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            m_ack <= 1'b0; m_dat <= '0; m_irq_en <= 1'b0; m_done <= 1'b0; m_irq <= 1'b0;
            m_phase <= -1;
            for (int i = 0; i < 3; i++) begin m_wgt[i] <= '0; m_in[i] <= '0; end
            for (int i = 0; i < 9; i++) m_res[i] <= '0;
        end else begin
            b_acc = stb && cyc && in_window(adr) && !m_ack;
            b_idx = int'((adr - BASE) >> 2);
            m_ack <= b_acc;
            if (b_acc && !we) m_dat <= m_read(adr);
            m_irq <= m_done && m_irq_en;
            if (b_acc && we && b_idx == 0) m_irq_en <= dat[2];
            if (b_acc && we && m_phase < 0 && b_idx >= 2 && b_idx <= 4) m_wgt[b_idx-2] <= dat[23:0];
            if (b_acc && we && m_phase < 0 && b_idx >= 5 && b_idx <= 7) m_in[b_idx-5] <= dat[23:0];
            if (b_acc && we && b_idx == 0 && dat[1]) begin
                m_phase <= -1;
                m_done  <= 1'b0;
                for (int i = 0; i < 9; i++) m_res[i] <= '0;
            end else if (m_phase < 0) begin
                if (b_acc && we && b_idx == 0 && dat[0]) begin
                    m_phase <= 0;
                    m_done  <= 1'b0;
                end
            end else if (m_phase == 8) begin
                m_phase <= -1;
                m_done  <= 1'b1;
                for (int k = 0; k < 3; k++)
                    for (int c = 0; c < 3; c++)
                        m_res[c*3 + k] <= prod(k, c);
            end else begin
                m_phase <= m_phase + 1;
            end
        end
    end

    always @(negedge clock) begin
        chk("ack",    {71'b0, wb_ack_o}, {71'b0, m_ack});
        chk("rdata",  {40'b0, wb_dat_o}, {40'b0, m_dat});
        chk("sa_en",  {71'b0, sa_en},    {71'b0, (m_phase >= 1 && m_phase <= 7)});
        chk("sa_clr", {71'b0, sa_clr},   {71'b0, (m_phase == 0)});
        chk("sa_in",  {48'b0, sa_in},    {48'b0, exp_in()});
        chk("sa_w",   sa_w,              {m_wgt[2], m_wgt[1], m_wgt[0]});
        chk("irq",    {71'b0, irq},      {71'b0, m_irq});
    end

    // Bus access, entered and left on a falling edge.
    task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                       output logic [31:0] rd, input string nm);
        logic got = 1'b0;
        adr = a; dat = d; we = w; stb = 1'b1; cyc = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clock);
            if (wb_ack_o) begin got = 1'b1; break; end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        rd = wb_dat_o;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_ack_timeout: got no ack expected ack at %0t", nm, $time);
        end
    endtask

    task automatic wr(input logic [7:0] ofs, input logic [31:0] d);
        logic [31:0] v;
        bus(BASE + 32'(ofs), 1'b1, d, v, "wr");
    endtask

    task automatic rd_chk(input logic [7:0] ofs, input logic [31:0] exp, input string nm);
        logic [31:0] v;
        bus(BASE + 32'(ofs), 1'b0, 32'h0, v, nm);
        chk(nm, {40'b0, v}, {40'b0, exp});
    endtask

    int unsigned id_res [9] = '{1, 4, 7, 2, 5, 8, 3, 6, 9};
    int unsigned n_ack;
    logic [31:0] probe_adr [3] = '{32'h3000_0044, 32'h2FFF_FFFC, 32'h3000_0080};

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        chk("rst_irq",   {71'b0, irq},   72'h0);
        chk("rst_sa_en", {71'b0, sa_en}, 72'h0);
        for (int i = 0; i < 17; i++) rd_chk(8'(4*i), 32'h0, "rst_read");

        // identity weights, START with IRQ_EN
        wr(8'h08, 32'h000001); wr(8'h0C, 32'h000100); wr(8'h10, 32'h010000);
        wr(8'h14, 32'h030201); wr(8'h18, 32'h060504); wr(8'h1C, 32'h090807);
        wr(8'h00, 32'h4);
        wr(8'h00, 32'h5);
        chk("lit_clr", {71'b0, sa_clr}, 72'h1);
        @(negedge clock);
        chk("lit_en_first", {71'b0, sa_en}, 72'h1);
        chk("lit_in0", {48'b0, sa_in}, 72'h030201);
        repeat (6) @(negedge clock);
        chk("lit_en_last", {71'b0, sa_en}, 72'h1);
        @(negedge clock);
        chk("lit_en_off", {71'b0, sa_en}, 72'h0);
        @(negedge clock);
        chk("lit_irq_lo", {71'b0, irq}, 72'h0);
        @(negedge clock);
        chk("lit_irq_hi", {71'b0, irq}, 72'h1);
        rd_chk(8'h04, 32'h2, "lit_status_done");
        for (int i = 0; i < 9; i++) rd_chk(8'(8'h20 + 4*i), id_res[i], "lit_res_id");

        // SOFT_CLR drops irq and results
        wr(8'h00, 32'h6);
        @(negedge clock);
        chk("lit_irq_dropped", {71'b0, irq}, 72'h0);
        rd_chk(8'h20, 32'h0, "lit_res_clr");
        rd_chk(8'h04, 32'h0, "lit_status_clr");
        rd_chk(8'h00, 32'h4, "lit_irq_en_kept");

        // START and WGT write while busy are acked and dropped
        wr(8'h00, 32'h1);
        wr(8'h00, 32'h1);
        wr(8'h08, 32'hFFFFFF);
        repeat (10) @(negedge clock);
        rd_chk(8'h08, 32'h000001, "lit_wgt_kept");
        rd_chk(8'h04, 32'h2, "lit_status_busy_run");
        for (int i = 0; i < 9; i++) rd_chk(8'(8'h20 + 4*i), id_res[i], "lit_res_busy_run");

        // SOFT_CLR while ops = 4
        wr(8'h00, 32'h1);
        repeat (5) @(negedge clock);
        chk("lit_ops4_en", {71'b0, sa_en}, 72'h1);
        wr(8'h00, 32'h2);
        chk("lit_abort_en", {71'b0, sa_en}, 72'h0);
        rd_chk(8'h04, 32'h0, "lit_status_abort");
        rd_chk(8'h20, 32'h0, "lit_res0_abort");
        rd_chk(8'h30, 32'h0, "lit_res4_abort");

        // all-ones weights: each result is the sum of an input row
        wr(8'h08, 32'h010101); wr(8'h0C, 32'h010101); wr(8'h10, 32'h010101);
        wr(8'h00, 32'h1);
        repeat (10) @(negedge clock);
        rd_chk(8'h04, 32'h2, "lit_status_ones");
        rd_chk(8'h20, 32'd6,  "lit_res0_ones");
        rd_chk(8'h2C, 32'd6,  "lit_res3_ones");
        rd_chk(8'h30, 32'd15, "lit_res4_ones");
        rd_chk(8'h40, 32'd24, "lit_res8_ones");
        wr(8'h20, 32'h1234);
        rd_chk(8'h20, 32'd6, "lit_res_readonly");

        // held strobe: one ack every other cycle
        adr = BASE + 32'h4; we = 1'b0; stb = 1'b1; cyc = 1'b1;
        n_ack = 0;
        repeat (4) begin @(negedge clock); if (wb_ack_o) n_ack++; end
        stb = 1'b0; cyc = 1'b0;
        chk("b2b_acks", 72'(n_ack), 72'd2);
        for (int p = 0; p < 3; p++) begin
            adr = probe_adr[p]; stb = 1'b1; cyc = 1'b1;
            n_ack = 0;
            repeat (4) begin @(negedge clock); if (wb_ack_o) n_ack++; end
            stb = 1'b0; cyc = 1'b0;
            chk("oow_acks", 72'(n_ack), 72'd0);
        end
        @(negedge clock);

        // asynchronous reset mid-run
        wr(8'h00, 32'h1);
        repeat (4) @(negedge clock);
        chk("lit_en_before_rst", {71'b0, sa_en}, 72'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("lit_rst_async_en", {71'b0, sa_en}, 72'h0);
        chk("lit_rst_async_ack", {71'b0, wb_ack_o}, 72'h0);
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        rd_chk(8'h20, 32'h0, "lit_res_after_rst");
        rd_chk(8'h08, 32'h0, "lit_wgt_after_rst");
        rd_chk(8'h04, 32'h0, "lit_status_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
